// File: rtl/mux_4_to_1_rr_pkg.sv
// Shared definitions for the 4-to-1 round-robin collector.
//   SEL_W / NUM_CH : width of a channel index and number of source channels
//   ch_e           : channel index encoding, identical to the demux control
//   out_state_e    : occupancy of the one-entry output register
//   next_ptr()     : priority pointer advance with 2-bit wrap (3 -> 0)
package mux_4_to_1_pkg;

  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [SEL_W-1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    return g + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux_4_to_1_rr_if.sv
// Bus bundle of the 4-to-1 round-robin collector.
//   in_data   : 4*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, at most one bit high
//   out_data  : forwarded word
//   out_sel   : source index of the forwarded word
//   out_valid : output word present
//   out_ready : downstream accepts the word
// Modports: master = source/sink side, slave = collector side.
interface mux_4_to_1_rr_if #(parameter int WIDTH = 1);
  import mux_4_to_1_pkg::*;

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_4_to_1_rr_arbiter.sv
// Combinational 4-way round-robin arbiter.
//   req     : request vector
//   ptr     : index searched first; search ascends mod 4
//   en      : grant enable; gnt is all-zero when low
//   gnt     : one-hot grant
//   gnt_idx : index of the winning request (equals ptr when nothing requests)
module rr_arbiter_4
  import mux_4_to_1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Walk from the farthest position back to ptr so that the nearest
  // requester (in ascending order from ptr) is the last one written.
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr;
    idx     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gnt
      assign gnt[gi] = en & found & (gnt_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux_4_to_1_rr.sv
// Registered 4-to-1 round-robin collector.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : collector side of mux_4_to_1_rr_if (four valid/ready sources in,
//         one registered valid/ready output carrying data and source index)
// The output register accepts a new word whenever it is empty or being
// drained in the same cycle, so back-to-back transfers run at full rate.
module mux_4_to_1_rr
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  mux_4_to_1_rr_if.slave   bus
);

  out_state_e        state_reg, state_next;
  logic [SEL_W-1:0]  ptr_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [SEL_W-1:0]  sel_reg;

  logic              load;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A load happens when someone requests and the output slot is free
  // now or frees up at this edge.
  assign load = (|bus.in_valid) & ((state_reg == EMPTY) | bus.out_ready);

  // Ready is suppressed during reset so no source believes it transferred.
  rr_arbiter_4 u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_reg),
    .en      (load & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.in_ready  = gnt;
  assign bus.out_data  = data_reg;
  assign bus.out_sel   = sel_reg;
  assign bus.out_valid = (state_reg == FULL);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (load) state_next = FULL;
      FULL: begin
        if (load)              state_next = FULL;
        else if (bus.out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= CH0;
      data_reg  <= '0;
      sel_reg   <= CH0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        data_reg <= ch_data[gnt_idx];
        sel_reg  <= gnt_idx;
        ptr_reg  <= next_ptr(gnt_idx);
      end
    end
  end

endmodule

// File: doc/mux_4_to_1_rr.md
Name: mux_4_to_1_rr

Overview:
- Registered 4-to-1 round-robin collector; the gathering counterpart of the 1-to-4 demultiplexer.
- Four source channels, each with valid/ready, compete for one output channel.
- Each forwarded word carries the 2-bit index of its source on out_sel, in the same encoding the demux consumes as its control.
- Output is a one-entry register, so a downstream demux can be driven directly and can stall.

Parameters:
- WIDTH, 1, data bits per channel (1 matches the single-bit demux input).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  4  per-channel valid.
- in_ready  output  4  per-channel ready; at most one bit is high per cycle.
- out_data  output  WIDTH  registered forwarded word.
- out_sel  output  2  registered source index: 2'b00 = ch0, 2'b01 = ch1, 2'b10 = ch2, 2'b11 = ch3.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high. No asynchronous logic anywhere.
- Reset values, applied at the first rising edge with rst=1:
  - out_valid=0, out_data=0, out_sel=2'b00.
  - Priority pointer ptr=2'b00, so channel 0 is searched first.
  - in_ready=4'b0000 while rst=1.
- State machine on out_valid:
  - EMPTY (out_valid=0) -> FULL on any load.
  - FULL -> EMPTY when out_ready=1 and no new load.
  - FULL -> FULL when the register is drained and reloaded in the same cycle.
- Load condition: load = (|in_valid) & (~out_valid | out_ready).
- Arbitration (combinational):
  - Search in_valid starting at index ptr, ascending mod 4 (ptr, ptr+1, ptr+2, ptr+3).
  - The first set bit is the winner g.
  - in_ready = onehot(g) when load, else 4'b0000.
- Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Then:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= g+1, with 2-bit wrap: 3 -> 0.
- Output drain: out_valid & out_ready at an edge with no load -> out_valid <= 0. out_data and out_sel keep their last value; they are don't-care while out_valid=0.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Full throughput of one word per cycle is sustained while out_ready=1. A simultaneous drain and load is legal and required.
- Stall: while out_valid=1 and out_ready=0:
  - out_data and out_sel are held stable.
  - in_ready=0 on all channels.
  - ptr is unchanged.
- Fairness: a continuously asserted channel waits at most 3 transfers of other channels before being granted.
- Source protocol rules:
  - Sources must not drop in_valid or change in_data before their transfer.
  - in_ready depends combinationally on in_valid. in_valid must not depend on in_ready.
- No valid inputs: ptr is unchanged and no load occurs.
- Reset mid-operation: a held word is discarded (out_valid=0 the next cycle) and ptr returns to 0. Reset overrides any simultaneous load.

Decomposition:
- Package mux_4_to_1_pkg:
  - SEL_W=2, NUM_CH=4.
  - Named encodings CH0..CH3 = 2'b00..2'b11, shared with the demux control.
- One sub-module: rr_arbiter_4. Inputs are req[3:0], ptr[1:0] and en. Outputs are gnt[3:0] (one-hot) and gnt_idx[1:0]. It is purely combinational.
- The top module holds the output register, the out_valid state and ptr.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_sel=0, in_ready=0. First grant after release goes to ch0 (in_ready=4'b0001).
- Rotation: in_valid=4'b1111 held, out_ready=1, in_data={1,0,1,1} (ch3..ch0) -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 1,1,0,1,1, out_valid continuously 1 after the first cycle.
- Skip and wrap: ptr=3 after a ch2 grant, then in_valid=4'b0010 -> ch1 granted, out_sel=2'b01, ptr becomes 2.
- Backpressure: out_valid=1 with out_sel=2, then out_ready=0 for 3 cycles while in_valid=4'b1011 -> out_data and out_sel are frozen and in_ready=0. When out_ready returns to 1, ch3 transfers in that same cycle.
- Drain to empty: single ch2 word, then in_valid=0 and out_ready=1 -> out_valid drops to 0 the cycle after the transfer, and ptr stays at 3.
- Reset mid-operation: out_valid=1 and out_ready=0, assert rst for 1 cycle -> out_valid=0. Next grant with in_valid=4'b1100 goes to ch2, searched from ptr=0.
